// File: rtl/credit_tx.sv
// credit_tx: transmit side of a credit-based link into a remote fifo whose
// depth equals the credit count. Turns an upstream valid/ready stream into
// valid-only beats and offers a flush/drain handshake that completes once
// every outstanding credit has come home.
// Optional feature: define CREDIT_TX_ERR_EN to add the sticky 'err' port
// that latches the first credit overflow.
module credit_tx #(
    parameter int unsigned data_size = 32,
    parameter int unsigned credits   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [data_size-1:0]           in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [data_size-1:0]           tx_data,
    output logic                           tx_valid,
    input  logic                           tx_credit,
    input  logic                           flush,
    output logic                           flush_done,
    output logic [$clog2(credits+1)-1:0]   credit_cnt
`ifdef CREDIT_TX_ERR_EN
    ,
    output logic                           err
`endif
);

    localparam int unsigned CNT_W = $clog2(credits + 1);
    localparam logic [CNT_W-1:0] CREDITS_C = CNT_W'(credits);

    // Reject configurations the link cannot operate with.
    if (credits < 1) begin : g_credits_chk
        $fatal(1, "credit_tx: credits must be >= 1");
    end
    if (data_size < 1) begin : g_width_chk
        $fatal(1, "credit_tx: data_size must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       credit_q, credit_d;
    logic [data_size-1:0]   tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   in_ready_q, in_ready_d;
    logic                   flush_done_q, flush_done_d;
    logic                   accept_c;
    logic                   overflow_c;

    // in_ready comes from a flop, so the handshake never loops through
    // in_valid or tx_credit.
    assign accept_c = in_valid && in_ready_q;

    // Credit bookkeeping: -1 per accepted beat, +1 per returned credit,
    // saturating at the remote fifo depth.
    always_comb begin
        credit_d   = credit_q;
        overflow_c = 1'b0;
        if (accept_c && !tx_credit) begin
            credit_d = credit_q - CNT_W'(1);
        end else if (!accept_c && tx_credit) begin
            if (credit_q == CREDITS_C) begin
                overflow_c = 1'b1;
            end else begin
                credit_d = credit_q + CNT_W'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACTIVE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a drain, once started, always runs to completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACTIVE: if (flush) state_d = ST_DRAIN;
            ST_DRAIN:  if ((credit_q == CREDITS_C) && !tx_valid_q) state_d = ST_DONE;
            ST_DONE:   if (!flush) state_d = ST_ACTIVE;
            default:   state_d = ST_ACTIVE;
        endcase
    end

    // FSM outputs, computed one cycle ahead so every port is a flop.
    always_comb begin
        in_ready_d   = 1'b0;
        flush_done_d = 1'b0;
        tx_valid_d   = accept_c;
        tx_data_d    = tx_data_q;
        if (accept_c) begin
            tx_data_d = in_data;
        end
        if ((state_d == ST_ACTIVE) && (credit_d != '0)) begin
            in_ready_d = 1'b1;
        end
        if (state_d == ST_DONE) begin
            flush_done_d = 1'b1;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q     <= CREDITS_C;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            in_ready_q   <= 1'b1;
            flush_done_q <= 1'b0;
        end else begin
            credit_q     <= credit_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            in_ready_q   <= in_ready_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign flush_done = flush_done_q;
    assign credit_cnt = credit_q;

`ifdef CREDIT_TX_ERR_EN
    logic err_q;

    // Sticky overflow flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (overflow_c) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

`ifndef SYNTHESIS
    // Report a credit returned while every credit is already home.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!overflow_c)
                else $warning("credit_tx: credit returned with all credits home, count saturated");
        end
    end
`endif

endmodule

// File: tb/tb_credit_tx.sv
// Bench for credit_tx (credits=4, data_size=8): scoreboard of accepted beats
// plus per-scenario checks of ready, count and flush handshake.
module tb_credit_tx;

    localparam int unsigned DW = 8;
    localparam int unsigned CR = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_credit;
    logic          flush;
    logic          flush_done;
    logic [2:0]    credit_cnt;
`ifdef CREDIT_TX_ERR_EN
    logic          err;
`endif

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    logic          exp_valid = 1'b0;

    credit_tx #(.data_size(DW), .credits(CR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_credit  (tx_credit),
        .flush      (flush),
        .flush_done (flush_done),
        .credit_cnt (credit_cnt)
`ifdef CREDIT_TX_ERR_EN
        ,
        .err        (err)
`endif
    );

    always #5 clk = ~clk;

    // Record each handshake; the beat is due on the link one cycle later.
    always @(posedge clk) begin
        exp_valid = rst_n && in_valid && in_ready;
        if (exp_valid) exp_q.push_back(in_data);
    end

    // Compare the link against the recorded handshakes.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            checks++;
            if (tx_valid !== exp_valid) begin
                errors++;
                $display("FAIL tx_valid: got %b expected %b at %0t", tx_valid, exp_valid, $time);
            end
            if (tx_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_beat: got unexpected beat %h at %0t", tx_data, $time);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL tx_data: got %h expected %h at %0t", tx_data, e, $time);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; tx_credit = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        checks++; if (credit_cnt !== 3'd4) begin errors++; $display("FAIL rst_credit_cnt: got %0d expected 4", credit_cnt); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
        checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL rst_flush_done: got %b expected 0", flush_done); end
`ifdef CREDIT_TX_ERR_EN
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
`endif
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_burst();
        int idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h10 + idx);
            checks++;
            if (in_ready !== 1'(c < 4)) begin errors++; $display("FAIL burst_in_ready[%0d]: got %b expected %b", c, in_ready, (c < 4)); end
            checks++;
            if (credit_cnt !== 3'(c < 4 ? 4 - c : 0)) begin errors++; $display("FAIL burst_credit_cnt[%0d]: got %0d expected %0d", c, credit_cnt, (c < 4 ? 4 - c : 0)); end
            if (in_ready) idx++;
            @(negedge clk);
        end
        checks++; if (credit_cnt !== 3'd0) begin errors++; $display("FAIL burst_end_cnt: got %0d expected 0", credit_cnt); end
    endtask

    task automatic test_credit_return();
        tx_credit = 1'b1;
        @(negedge clk);
        tx_credit = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ret_in_ready: got %b expected 1", in_ready); end
        checks++; if (credit_cnt !== 3'd1) begin errors++; $display("FAIL ret_credit_cnt: got %0d expected 1", credit_cnt); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ret_in_ready_after: got %b expected 0", in_ready); end
        checks++; if (credit_cnt !== 3'd0) begin errors++; $display("FAIL ret_cnt_after: got %0d expected 0", credit_cnt); end
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        tx_credit = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (credit_cnt !== 3'd2) begin errors++; $display("FAIL sim_start_cnt: got %0d expected 2", credit_cnt); end
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            tx_credit = 1'b1;
            in_data   = 8'(8'h20 + i);
            @(negedge clk);
            checks++; if (credit_cnt !== 3'd2) begin errors++; $display("FAIL sim_cnt[%0d]: got %0d expected 2", i, credit_cnt); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sim_in_ready[%0d]: got %b expected 1", i, in_ready); end
        end
        in_valid  = 1'b0;
        tx_credit = 1'b0;
        @(negedge clk);
        checks++; if (credit_cnt !== 3'd2) begin errors++; $display("FAIL sim_end_cnt: got %0d expected 2", credit_cnt); end
    endtask

    task automatic test_drain();
        int exp_cnt;
        tx_credit = 1'b1;
        repeat (2) @(negedge clk);
        tx_credit = 1'b0;
        checks++; if (credit_cnt !== 3'd4) begin errors++; $display("FAIL drain_full_cnt: got %0d expected 4", credit_cnt); end
        in_valid = 1'b1; in_data = 8'h30;
        @(negedge clk);
        in_data = 8'h31;
        @(negedge clk);
        for (int k = 0; k < 13; k++) begin
            exp_cnt = (k == 0) ? 2 : (k < 3) ? 1 : (k < 6) ? 2 : (k < 10) ? 3 : 4;
            checks++;
            if (credit_cnt !== 3'(exp_cnt)) begin errors++; $display("FAIL drain_cnt[%0d]: got %0d expected %0d", k, credit_cnt, exp_cnt); end
            checks++;
            if (in_ready !== 1'(k == 0)) begin errors++; $display("FAIL drain_in_ready[%0d]: got %b expected %b", k, in_ready, (k == 0)); end
            checks++;
            if (flush_done !== 1'(k >= 11)) begin errors++; $display("FAIL drain_flush_done[%0d]: got %b expected %b", k, flush_done, (k >= 11)); end
            in_valid  = (k == 0);
            in_data   = 8'h32;
            flush     = 1'b1;
            tx_credit = (k == 2) || (k == 5) || (k == 9);
            @(negedge clk);
        end
        tx_credit = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL drain_exit_done: got %b expected 0", flush_done); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_exit_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_flush_idle();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL idle_done_c1: got %b expected 0", flush_done); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_ready_c1: got %b expected 0", in_ready); end
        @(negedge clk);
        checks++; if (flush_done !== 1'b1) begin errors++; $display("FAIL idle_done_c2: got %b expected 1", flush_done); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_ready_c2: got %b expected 0", in_ready); end
        @(negedge clk);
        checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL idle_done_c3: got %b expected 0", flush_done); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_ready_c3: got %b expected 1", in_ready); end
    endtask

    task automatic test_overflow();
        tx_credit = 1'b1;
        @(negedge clk);
        tx_credit = 1'b0;
        checks++; if (credit_cnt !== 3'd4) begin errors++; $display("FAIL ovf_cnt: got %0d expected 4", credit_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ovf_in_ready: got %b expected 1", in_ready); end
`ifdef CREDIT_TX_ERR_EN
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b expected 1", err); end
`endif
    endtask

    task automatic test_reset_mid_burst();
        in_valid = 1'b1; in_data = 8'h40;
        @(negedge clk);
        in_data = 8'h41;
        @(negedge clk);
        in_data = 8'h42;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL mid_rst_tx_data: got %h expected 00", tx_data); end
        checks++; if (credit_cnt !== 3'd4) begin errors++; $display("FAIL mid_rst_cnt: got %0d expected 4", credit_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready: got %b expected 1", in_ready); end
        checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL mid_rst_flush_done: got %b expected 0", flush_done); end
`ifdef CREDIT_TX_ERR_EN
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %b expected 0", err); end
`endif
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_empty: got %0d pending expected 0", exp_q.size()); end
        checks++; if (credit_cnt !== 3'd4) begin errors++; $display("FAIL post_rst_cnt: got %0d expected 4", credit_cnt); end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_credit_return();
        test_simultaneous();
        test_drain();
        test_flush_idle();
        test_overflow();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
